// File: rtl/ex_mem_stage_if.sv
// Signal bundle between ID/EX, the execute stage and the EX/MEM register.
// The master drives the ID/EX and forwarding side; the slave is the stage itself.
interface ex_mem_stage_if #(
    parameter int DATA_W = 32
);
    logic              ex_reg_write;
    logic              ex_mem_to_reg;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_alu_src;
    logic [2:0]        ex_alu_ctrl;
    logic              ex_reg_dst;
    logic              ex_no_dest;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_immediate;
    logic [4:0]        ex_rt_reg;
    logic [4:0]        ex_rd_reg;
    logic [31:0]       ex_instruction;
    logic [1:0]        forward_a;
    logic [1:0]        forward_b;
    logic [DATA_W-1:0] mem_alu_result_fwd;
    logic [DATA_W-1:0] wb_write_data;

    logic              ex_stall;
    logic              mem_reg_write;
    logic              mem_mem_to_reg;
    logic              mem_mem_read;
    logic              mem_mem_write;
    logic [DATA_W-1:0] mem_alu_result;
    logic [DATA_W-1:0] mem_store_data;
    logic [4:0]        mem_dest_reg;
    logic [31:0]       mem_instruction;

    modport master (
        output ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src,
               ex_alu_ctrl, ex_reg_dst, ex_no_dest, ex_rs_data, ex_rt_data,
               ex_immediate, ex_rt_reg, ex_rd_reg, ex_instruction, forward_a,
               forward_b, mem_alu_result_fwd, wb_write_data,
        input  ex_stall, mem_reg_write, mem_mem_to_reg, mem_mem_read, mem_mem_write,
               mem_alu_result, mem_store_data, mem_dest_reg, mem_instruction
    );

    modport slave (
        input  ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_alu_src,
               ex_alu_ctrl, ex_reg_dst, ex_no_dest, ex_rs_data, ex_rt_data,
               ex_immediate, ex_rt_reg, ex_rd_reg, ex_instruction, forward_a,
               forward_b, mem_alu_result_fwd, wb_write_data,
        output ex_stall, mem_reg_write, mem_mem_to_reg, mem_mem_read, mem_mem_write,
               mem_alu_result, mem_store_data, mem_dest_reg, mem_instruction
    );
endinterface

// File: rtl/ex_mem_stage.sv
// Execute stage with operand forwarding, ALU and EX/MEM register.
// MUL runs as a shift-add loop over DATA_W cycles while ex_stall holds the front end.
//
// state | meaning
// IDLE  | single-cycle ops pass straight through; a MUL latches operands here
// MUL   | one shift-add step per cycle, EX/MEM receives bubbles
// DONE  | product is written to EX/MEM with the held controls
module ex_mem_stage #(
    parameter int DATA_W = 32
) (
    input logic           clk,
    input logic           rst_n,
    ex_mem_stage_if.slave bus
);
    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_NOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] mul_a;
    logic [DATA_W-1:0] mul_b;
    logic [DATA_W-1:0] product;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] result;
    logic [4:0]        dest;
    logic              mul_req;
    logic              load_en;

    always_comb begin
        case (bus.forward_a)
            2'b01:   op_a = bus.wb_write_data;
            2'b10:   op_a = bus.mem_alu_result_fwd;
            default: op_a = bus.ex_rs_data;
        endcase
        case (bus.forward_b)
            2'b01:   fwd_b = bus.wb_write_data;
            2'b10:   fwd_b = bus.mem_alu_result_fwd;
            default: fwd_b = bus.ex_rt_data;
        endcase
        op_b = bus.ex_alu_src ? bus.ex_immediate : fwd_b;
    end

    always_comb begin
        case (bus.ex_alu_ctrl)
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_ADD:  alu_res = op_a + op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_NOR:  alu_res = ~(op_a | op_b);
            OP_SUB:  alu_res = op_a - op_b;
            OP_SLT:  alu_res = DATA_W'($signed(op_a) < $signed(op_b));
            default: alu_res = '0;
        endcase
    end

    assign mul_req      = (bus.ex_alu_ctrl == OP_MUL);
    assign dest         = bus.ex_no_dest ? 5'd0 : (bus.ex_reg_dst ? bus.ex_rd_reg : bus.ex_rt_reg);
    assign result       = (state == DONE) ? product : alu_res;
    // EX/MEM takes real data only outside the multiply loop; everything else is a bubble
    assign load_en      = (state == DONE) || (state == IDLE && !mul_req);
    assign bus.ex_stall = (state == IDLE && mul_req) || (state == MUL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            cnt                 <= '0;
            mul_a               <= '0;
            mul_b               <= '0;
            product             <= '0;
            bus.mem_reg_write   <= 1'b0;
            bus.mem_mem_to_reg  <= 1'b0;
            bus.mem_mem_read    <= 1'b0;
            bus.mem_mem_write   <= 1'b0;
            bus.mem_alu_result  <= '0;
            bus.mem_store_data  <= '0;
            bus.mem_dest_reg    <= '0;
            bus.mem_instruction <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mul_req) begin
                        mul_a   <= op_a;
                        mul_b   <= op_b;
                        product <= '0;
                        cnt     <= '0;
                        state   <= MUL;
                    end
                end
                MUL: begin
                    if (mul_b[cnt]) product <= product + (mul_a << cnt);
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase

            if (load_en) begin
                bus.mem_reg_write   <= bus.ex_reg_write & ~bus.ex_no_dest;
                bus.mem_mem_to_reg  <= bus.ex_mem_to_reg;
                bus.mem_mem_read    <= bus.ex_mem_read;
                bus.mem_mem_write   <= bus.ex_mem_write;
                bus.mem_alu_result  <= result;
                bus.mem_store_data  <= fwd_b;
                bus.mem_dest_reg    <= dest;
                bus.mem_instruction <= bus.ex_instruction;
            end else begin
                bus.mem_reg_write   <= 1'b0;
                bus.mem_mem_to_reg  <= 1'b0;
                bus.mem_mem_read    <= 1'b0;
                bus.mem_mem_write   <= 1'b0;
                bus.mem_alu_result  <= '0;
                bus.mem_store_data  <= '0;
                bus.mem_dest_reg    <= '0;
                bus.mem_instruction <= '0;
            end
        end
    end
endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: expected EX/MEM contents are queued as each op is driven
// and compared one clock edge later.
module tb_ex_mem_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ex_mem_stage_if #(.DATA_W(32)) bus();

    ex_mem_stage #(.DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic        mtr;
        logic        mr;
        logic        mw;
        logic [31:0] res;
        logic [31:0] st;
        logic [4:0]  dest;
        logic [31:0] ins;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h @%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd_val(input logic [1:0] sel, input logic [31:0] reg_v);
        if (sel == 2'b01) return bus.wb_write_data;
        if (sel == 2'b10) return bus.mem_alu_result_fwd;
        return reg_v;
    endfunction

    // Reference model of one single-cycle op from the currently driven inputs
    function automatic exp_t model_exp();
        exp_t        e;
        logic [31:0] a, b;
        a = fwd_val(bus.forward_a, bus.ex_rs_data);
        b = bus.ex_alu_src ? bus.ex_immediate : fwd_val(bus.forward_b, bus.ex_rt_data);
        case (bus.ex_alu_ctrl)
            3'd0: e.res = a & b;
            3'd1: e.res = a | b;
            3'd2: e.res = a + b;
            3'd3: e.res = a ^ b;
            3'd4: e.res = ~a & ~b;
            3'd6: e.res = a + ~b + 32'd1;
            3'd7: e.res = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
            default: e.res = 32'd0;
        endcase
        e.rw   = bus.ex_no_dest ? 1'b0 : bus.ex_reg_write;
        e.mtr  = bus.ex_mem_to_reg;
        e.mr   = bus.ex_mem_read;
        e.mw   = bus.ex_mem_write;
        e.st   = fwd_val(bus.forward_b, bus.ex_rt_data);
        e.dest = bus.ex_no_dest ? 5'd0 : (bus.ex_reg_dst ? bus.ex_rd_reg : bus.ex_rt_reg);
        e.ins  = bus.ex_instruction;
        return e;
    endfunction

    function automatic exp_t bubble();
        exp_t e;
        e.rw = 1'b0; e.mtr = 1'b0; e.mr = 1'b0; e.mw = 1'b0;
        e.res = 32'd0; e.st = 32'd0; e.dest = 5'd0; e.ins = 32'd0;
        return e;
    endfunction

    task automatic clear_inputs();
        bus.ex_reg_write = 0; bus.ex_mem_to_reg = 0; bus.ex_mem_read = 0; bus.ex_mem_write = 0;
        bus.ex_alu_src = 0; bus.ex_alu_ctrl = 3'd0; bus.ex_reg_dst = 0; bus.ex_no_dest = 0;
        bus.ex_rs_data = 0; bus.ex_rt_data = 0; bus.ex_immediate = 0;
        bus.ex_rt_reg = 0; bus.ex_rd_reg = 0; bus.ex_instruction = 0;
        bus.forward_a = 0; bus.forward_b = 0; bus.mem_alu_result_fwd = 0; bus.wb_write_data = 0;
    endtask

    task automatic check_stall(input string tag, input logic exp);
        #1;
        check(tag, {31'd0, bus.ex_stall}, {31'd0, exp});
    endtask

    task automatic tick_check(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_rw"},   {31'd0, bus.mem_reg_write},  {31'd0, e.rw});
            check({tag, "_mtr"},  {31'd0, bus.mem_mem_to_reg}, {31'd0, e.mtr});
            check({tag, "_mr"},   {31'd0, bus.mem_mem_read},   {31'd0, e.mr});
            check({tag, "_mw"},   {31'd0, bus.mem_mem_write},  {31'd0, e.mw});
            check({tag, "_res"},  bus.mem_alu_result,          e.res);
            check({tag, "_st"},   bus.mem_store_data,          e.st);
            check({tag, "_dest"}, {27'd0, bus.mem_dest_reg},   {27'd0, e.dest});
            check({tag, "_ins"},  bus.mem_instruction,         e.ins);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_stall"}, {31'd0, bus.ex_stall}, 32'd0);
        check({tag, "_ctl"}, {28'd0, bus.mem_reg_write, bus.mem_mem_to_reg,
                              bus.mem_mem_read, bus.mem_mem_write}, 32'd0);
        check({tag, "_res"}, bus.mem_alu_result, 32'd0);
        check({tag, "_st"}, bus.mem_store_data, 32'd0);
        check({tag, "_dest"}, {27'd0, bus.mem_dest_reg}, 32'd0);
        check({tag, "_ins"}, bus.mem_instruction, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        clear_inputs();
        #2;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: ADD 5+7 into Rd=3
        clear_inputs();
        bus.ex_alu_ctrl = 3'd2; bus.ex_rs_data = 5; bus.ex_rt_data = 7;
        bus.ex_reg_dst = 1; bus.ex_rd_reg = 3; bus.ex_rt_reg = 9; bus.ex_reg_write = 1;
        bus.ex_instruction = 32'h0085_1820;
        e = model_exp(); e.res = 32'd12; e.dest = 5'd3; e.rw = 1'b1; sb.push_back(e);
        check_stall("add_stall", 1'b0);
        tick_check("add");

        // 2: SUB, SLT, ADDI wrap
        clear_inputs();
        bus.ex_alu_ctrl = 3'd6; bus.ex_rs_data = 3; bus.ex_rt_data = 5; bus.ex_reg_write = 1;
        bus.ex_rt_reg = 4;
        e = model_exp(); e.res = 32'hFFFF_FFFE; sb.push_back(e);
        tick_check("sub");
        clear_inputs();
        bus.ex_alu_ctrl = 3'd7; bus.ex_rs_data = 32'hFFFF_FFFF; bus.ex_rt_data = 1;
        e = model_exp(); e.res = 32'd1; sb.push_back(e);
        tick_check("slt");
        clear_inputs();
        bus.ex_alu_ctrl = 3'd2; bus.ex_alu_src = 1; bus.ex_immediate = 32'hFFFF_FFFF;
        bus.ex_rs_data = 1; bus.ex_rt_data = 32'h55; bus.ex_mem_write = 1;
        e = model_exp(); e.res = 32'd0; e.st = 32'h55; sb.push_back(e);
        tick_check("addi");

        // 3: forwarding from both later stages
        clear_inputs();
        bus.ex_alu_ctrl = 3'd2; bus.forward_a = 2'b10; bus.forward_b = 2'b01;
        bus.mem_alu_result_fwd = 100; bus.wb_write_data = 20;
        bus.ex_rs_data = 32'hDEAD; bus.ex_rt_data = 32'hBEEF;
        e = model_exp(); e.res = 32'd120; e.st = 32'd20; sb.push_back(e);
        tick_check("fwd");

        // NoDest suppresses RegWrite and zeroes dest
        clear_inputs();
        bus.ex_alu_ctrl = 3'd1; bus.ex_rs_data = 32'hF0; bus.ex_rt_data = 32'h0F;
        bus.ex_reg_write = 1; bus.ex_reg_dst = 1; bus.ex_rd_reg = 17; bus.ex_no_dest = 1;
        e = model_exp(); e.rw = 1'b0; e.dest = 5'd0; sb.push_back(e);
        tick_check("nodest");

        // random single-cycle ops
        for (int i = 0; i < 20; i++) begin
            clear_inputs();
            bus.ex_alu_ctrl = 3'($urandom_range(0, 7));
            if (bus.ex_alu_ctrl == 3'd5) bus.ex_alu_ctrl = 3'd6;
            bus.ex_rs_data = $urandom; bus.ex_rt_data = $urandom; bus.ex_immediate = $urandom;
            bus.mem_alu_result_fwd = $urandom; bus.wb_write_data = $urandom;
            bus.forward_a = 2'($urandom_range(0, 3)); bus.forward_b = 2'($urandom_range(0, 3));
            bus.ex_alu_src = 1'($urandom_range(0, 1)); bus.ex_reg_dst = 1'($urandom_range(0, 1));
            bus.ex_no_dest = 1'($urandom_range(0, 3) == 0);
            bus.ex_reg_write = 1'($urandom_range(0, 1)); bus.ex_mem_to_reg = 1'($urandom_range(0, 1));
            bus.ex_mem_read = 1'($urandom_range(0, 1)); bus.ex_mem_write = 1'($urandom_range(0, 1));
            bus.ex_rt_reg = 5'($urandom); bus.ex_rd_reg = 5'($urandom); bus.ex_instruction = $urandom;
            sb.push_back(model_exp());
            tick_check("rand");
        end

        // 4: MUL 6*7, 33 stalled cycles of bubbles then one result
        clear_inputs();
        bus.ex_alu_ctrl = 3'd5; bus.ex_rs_data = 6; bus.ex_rt_data = 7;
        bus.ex_reg_write = 1; bus.ex_reg_dst = 1; bus.ex_rd_reg = 9; bus.ex_instruction = 32'h00C7_4818;
        for (int i = 0; i < 33; i++) begin
            check_stall("mul_stall", 1'b1);
            sb.push_back(bubble());
            tick_check("mul_bubble");
        end
        check_stall("mul_done_stall", 1'b0);
        e = model_exp(); e.res = 32'd42; e.dest = 5'd9; e.rw = 1'b1; sb.push_back(e);
        tick_check("mul_result");
        clear_inputs();
        sb.push_back(bubble());
        tick_check("after_mul");

        // 5: MUL with forwarded operands that change during the stall
        clear_inputs();
        bus.ex_alu_ctrl = 3'd5; bus.forward_a = 2'b10; bus.forward_b = 2'b01;
        bus.mem_alu_result_fwd = 32'hFFFF_FFFF; bus.wb_write_data = 2;
        bus.ex_reg_write = 1; bus.ex_rt_reg = 12; bus.ex_instruction = 32'h1234_5678;
        for (int i = 0; i < 33; i++) begin
            if (i == 5) begin
                bus.mem_alu_result_fwd = 32'h0000_0003; bus.wb_write_data = 32'h0000_0003;
            end
            sb.push_back(bubble());
            tick_check("mul2_bubble");
        end
        check_stall("mul2_done_stall", 1'b0);
        e = model_exp(); e.res = 32'hFFFF_FFFE; e.st = 32'd3; sb.push_back(e);
        tick_check("mul2_result");

        // back-to-back MUL: the second one starts right after DONE
        clear_inputs();
        bus.ex_alu_ctrl = 3'd5; bus.ex_rs_data = 32'h0001_0001; bus.ex_rt_data = 32'h0000_0010;
        bus.ex_reg_write = 1; bus.ex_rt_reg = 2;
        for (int i = 0; i < 33; i++) begin
            sb.push_back(bubble());
            tick_check("mul3_bubble");
        end
        e = model_exp(); e.res = 32'h0010_0010; sb.push_back(e);
        tick_check("mul3_result");

        // 6: reset in the middle of a MUL
        clear_inputs();
        bus.ex_alu_ctrl = 3'd5; bus.ex_rs_data = 9; bus.ex_rt_data = 9; bus.ex_reg_write = 1;
        for (int i = 0; i < 10; i++) begin
            sb.push_back(bubble());
            tick_check("mul4_bubble");
        end
        #2;
        rst_n = 1'b0;
        clear_inputs();
        #1;
        check_zero_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        bus.ex_alu_ctrl = 3'd2; bus.ex_rs_data = 1; bus.ex_rt_data = 1;
        bus.ex_reg_write = 1; bus.ex_rt_reg = 6;
        check_stall("post_reset_stall", 1'b0);
        e = model_exp(); e.res = 32'd2; e.rw = 1'b1; e.dest = 5'd6; sb.push_back(e);
        tick_check("post_reset_add");

        // a zeroed ID/EX bubble flows through as zeros
        clear_inputs();
        sb.push_back(bubble());
        tick_check("flush_bubble");

        check("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
